router_fsm: RTL and testbench

ROUTER_FSM -- requirements
Module: router_fsm

---
 rtl/router_pkg.sv | 33 +++
 rtl/router_fsm.sv | 147 ++++++++++++++
 tb/tb_router_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the router: FSM state encoding, port count and the
// reserved header address, plus a helper that picks one port's flag bit.
package router_pkg;

  localparam int NUM_PORTS = 3;
  localparam logic [1:0] ADDR_INVALID = 2'b11;

  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    FIFO_FULL_STATE    = 3'd3,
    LOAD_AFTER_FULL    = 3'd4,
    LOAD_PARITY        = 3'd5,
    CHECK_PARITY_ERROR = 3'd6,
    WAIT_TILL_EMPTY    = 3'd7
  } router_state_t;

  // Select the flag of one output port; the reserved address yields 0 so it
  // can never trigger anything.
  function automatic logic port_flag(input logic [NUM_PORTS-1:0] flags,
                                     input logic [1:0] port);
    logic bit_sel;
    case (port)
      2'd0:    bit_sel = flags[0];
      2'd1:    bit_sel = flags[1];
      2'd2:    bit_sel = flags[2];
      default: bit_sel = 1'b0;
    endcase
    return bit_sel;
  endfunction

endpackage

// File: rtl/router_fsm.sv
// Router control FSM: decodes the header address, sequences payload, FIFO
// full handling and parity phases. Moore machine, all outputs are decoded
// from the state register only (no input-to-output combinational path).
module router_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data,
  input  logic       fifo_full,
  input  logic [2:0] fifo_empty,
  input  logic [2:0] soft_reset,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic [1:0] addr,
  output logic       busy,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       write_enb_reg,
  output logic       rst_int_reg
);

  router_state_t state_reg, state_next;
  logic [1:0]    addr_reg, addr_next;

  // Header is usable only with a valid byte carrying a real port number.
  logic header_ok;
  assign header_ok = pkt_valid && (data != ADDR_INVALID);

  // State and latched address registers; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= DECODE_ADDRESS;
      addr_reg  <= 2'b00;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  // Next-state and address-capture logic; soft reset of the active port wins
  // over every normal transition outside DECODE_ADDRESS.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    case (state_reg)
      DECODE_ADDRESS: begin
        if (header_ok) begin
          addr_next = data;
          if (port_flag(fifo_empty, data))
            state_next = LOAD_FIRST_DATA;
          else
            state_next = WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY: begin
        if (port_flag(fifo_empty, addr_reg))
          state_next = LOAD_FIRST_DATA;
      end
      LOAD_FIRST_DATA: begin
        state_next = LOAD_DATA;
      end
      LOAD_DATA: begin
        if (fifo_full)
          state_next = FIFO_FULL_STATE;
        else if (!pkt_valid)
          state_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!fifo_full)
          state_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (parity_done)
          state_next = DECODE_ADDRESS;
        else if (low_pkt_valid)
          state_next = LOAD_PARITY;
        else
          state_next = LOAD_DATA;
      end
      LOAD_PARITY: begin
        state_next = CHECK_PARITY_ERROR;
      end
      CHECK_PARITY_ERROR: begin
        if (fifo_full)
          state_next = FIFO_FULL_STATE;
        else
          state_next = DECODE_ADDRESS;
      end
      default: begin
        state_next = DECODE_ADDRESS;
      end
    endcase

    if ((state_reg != DECODE_ADDRESS) && port_flag(soft_reset, addr_reg))
      state_next = DECODE_ADDRESS;
  end

  // Output decode from the current state only.
  always_comb begin
    busy          = 1'b1;
    detect_add    = 1'b0;
    lfd_state     = 1'b0;
    ld_state      = 1'b0;
    laf_state     = 1'b0;
    full_state    = 1'b0;
    write_enb_reg = 1'b0;
    rst_int_reg   = 1'b0;
    case (state_reg)
      DECODE_ADDRESS: begin
        detect_add = 1'b1;
        busy       = 1'b0;
      end
      LOAD_FIRST_DATA: begin
        lfd_state = 1'b1;
      end
      LOAD_DATA: begin
        ld_state      = 1'b1;
        write_enb_reg = 1'b1;
        busy          = 1'b0;
      end
      FIFO_FULL_STATE: begin
        full_state = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        laf_state     = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        rst_int_reg = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  assign addr = addr_reg;

endmodule

// File: tb/tb_router_fsm.sv
// Directed bench for router_fsm: each step drives inputs, queues the output
// vector expected after the next edge, then pops and checks it.
module tb_router_fsm;
  import router_pkg::*;

  logic       clk;
  logic       rst;
  logic       pkt_valid;
  logic [1:0] data;
  logic       fifo_full;
  logic [2:0] fifo_empty;
  logic [2:0] soft_reset;
  logic       parity_done;
  logic       low_pkt_valid;
  logic [1:0] addr;
  logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
  logic       write_enb_reg, rst_int_reg;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string      tag;
    logic [9:0] val;
  } exp_t;

  exp_t sb[$];

  router_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data(data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .soft_reset(soft_reset),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .addr(addr), .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state),
    .ld_state(ld_state), .laf_state(laf_state), .full_state(full_state),
    .write_enb_reg(write_enb_reg), .rst_int_reg(rst_int_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {addr, busy, detect_add, lfd, ld, laf, full, write_enb, rst_int}.
  function automatic logic [9:0] model(input router_state_t s, input logic [1:0] a);
    logic [7:0] f;
    case (s)
      DECODE_ADDRESS:     f = 8'b0100_0000;
      LOAD_FIRST_DATA:    f = 8'b1010_0000;
      LOAD_DATA:          f = 8'b0001_0010;
      FIFO_FULL_STATE:    f = 8'b1000_0100;
      LOAD_AFTER_FULL:    f = 8'b1000_1010;
      LOAD_PARITY:        f = 8'b1000_0010;
      CHECK_PARITY_ERROR: f = 8'b1000_0001;
      default:            f = 8'b1000_0000;
    endcase
    return {a, f};
  endfunction

  task automatic step(input string tag, input router_state_t s, input logic [1:0] a);
    exp_t e;
    logic [9:0] obs;
    e.tag = tag;
    e.val = model(s, a);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs = {addr, busy, detect_add, lfd_state, ld_state, laf_state,
           full_state, write_enb_reg, rst_int_reg};
    tests++;
    assert (obs === e.val) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", e.tag, obs, e.val);
    end
    $display("[TB] %s addr=%0d busy=%0b flags=%b", e.tag, addr, busy, obs[7:0]);
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; data = 2'd0; fifo_full = 1'b0;
    fifo_empty = 3'b111; soft_reset = 3'b000; parity_done = 1'b0;
    low_pkt_valid = 1'b0;
    #1;
    step("reset0", DECODE_ADDRESS, 2'd0);
    step("reset1", DECODE_ADDRESS, 2'd0);
    rst = 1'b1;
    step("idle", DECODE_ADDRESS, 2'd0);

    // Normal packet to port 1, four payload cycles.
    pkt_valid = 1'b1; data = 2'd1;
    step("n_hdr", LOAD_FIRST_DATA, 2'd1);
    data = 2'd0;
    step("n_ld1", LOAD_DATA, 2'd1);
    step("n_ld2", LOAD_DATA, 2'd1);
    step("n_ld3", LOAD_DATA, 2'd1);
    step("n_ld4", LOAD_DATA, 2'd1);
    pkt_valid = 1'b0;
    step("n_lp", LOAD_PARITY, 2'd1);
    step("n_cpe", CHECK_PARITY_ERROR, 2'd1);
    step("n_done", DECODE_ADDRESS, 2'd1);

    // Reserved header address is ignored, addr keeps its old value.
    pkt_valid = 1'b1; data = 2'd3;
    step("inv_hdr0", DECODE_ADDRESS, 2'd1);
    step("inv_hdr1", DECODE_ADDRESS, 2'd1);

    // Busy destination: port 2 not empty for six cycles.
    data = 2'd2; fifo_empty = 3'b011;
    step("w_hdr", WAIT_TILL_EMPTY, 2'd2);
    pkt_valid = 1'b0; data = 2'd0;
    for (int i = 0; i < 5; i++) step("w_wait", WAIT_TILL_EMPTY, 2'd2);
    fifo_empty = 3'b111;
    step("w_lfd", LOAD_FIRST_DATA, 2'd2);
    pkt_valid = 1'b1;
    step("w_ld", LOAD_DATA, 2'd2);

    // FIFO full mid-packet, full has priority over a dropped pkt_valid.
    fifo_full = 1'b1; pkt_valid = 1'b0;
    step("f_full1", FIFO_FULL_STATE, 2'd2);
    step("f_full2", FIFO_FULL_STATE, 2'd2);
    step("f_full3", FIFO_FULL_STATE, 2'd2);
    fifo_full = 1'b0; pkt_valid = 1'b1;
    step("f_laf", LOAD_AFTER_FULL, 2'd2);
    step("f_ld", LOAD_DATA, 2'd2);
    pkt_valid = 1'b0;
    step("f_lp", LOAD_PARITY, 2'd2);
    fifo_full = 1'b1;
    step("f_cpe", CHECK_PARITY_ERROR, 2'd2);
    step("f_cpe_full", FIFO_FULL_STATE, 2'd2);
    fifo_full = 1'b0;
    step("f_laf2", LOAD_AFTER_FULL, 2'd2);
    low_pkt_valid = 1'b1;
    step("f_laf_low", LOAD_PARITY, 2'd2);
    low_pkt_valid = 1'b0;
    step("f_cpe2", CHECK_PARITY_ERROR, 2'd2);
    step("f_done", DECODE_ADDRESS, 2'd2);

    // Soft reset of the active port aborts the packet.
    pkt_valid = 1'b1; data = 2'd1;
    step("sa_hdr", LOAD_FIRST_DATA, 2'd1);
    step("sa_ld", LOAD_DATA, 2'd1);
    soft_reset = 3'b010;
    step("sa_soft", DECODE_ADDRESS, 2'd1);
    soft_reset = 3'b000;

    // Soft reset of other ports has no effect.
    step("sb_hdr", LOAD_FIRST_DATA, 2'd1);
    step("sb_ld", LOAD_DATA, 2'd1);
    soft_reset = 3'b001;
    step("sb_soft0", LOAD_DATA, 2'd1);
    soft_reset = 3'b100;
    step("sb_soft2", LOAD_DATA, 2'd1);
    soft_reset = 3'b000;

    // Hard reset while full, with a competing soft reset.
    fifo_full = 1'b1;
    step("sc_full", FIFO_FULL_STATE, 2'd1);
    rst = 1'b0; soft_reset = 3'b010;
    step("sc_rst", DECODE_ADDRESS, 2'd0);
    rst = 1'b1; soft_reset = 3'b000; fifo_full = 1'b0; pkt_valid = 1'b0;
    step("sc_idle", DECODE_ADDRESS, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
